// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK-style cells with runtime mode select (JK/D/T/SR/count/clear),
// clock enable, combinational terminal count, sticky illegal-SR flag and change pulse.
module jk_reg_bank #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             err,
  output logic             changed
);

  localparam logic [2:0] ModeHold   = 3'd0;
  localparam logic [2:0] ModeJk     = 3'd1;
  localparam logic [2:0] ModeD      = 3'd2;
  localparam logic [2:0] ModeT      = 3'd3;
  localparam logic [2:0] ModeSr     = 3'd4;
  localparam logic [2:0] ModeCntUp  = 3'd5;
  localparam logic [2:0] ModeCntDn  = 3'd6;
  localparam logic [2:0] ModeClear  = 3'd7;

  logic [WIDTH-1:0] q_q, q_d;
  logic             err_q, err_d;
  logic             changed_q, changed_d;
  logic [WIDTH-1:0] next_val;
  logic             err_next;

  // Per-mode next value; j/k are not read in modes that ignore them so X cannot leak in.
  always_comb begin
    next_val = q_q;
    err_next = err_q;
    case (mode)
      ModeHold:  next_val = q_q;
      ModeJk:    next_val = (j & ~q_q) | (~k & q_q);
      ModeD:     next_val = j;
      ModeT:     next_val = q_q ^ j;
      ModeSr: begin
        // Conflicting bits (j=k=1) keep their value; the rest update normally.
        next_val = (q_q & ~(j ^ k)) | (j & ~k);
        if ((j & k) != '0) err_next = 1'b1;
      end
      ModeCntUp: next_val = q_q + WIDTH'(1);
      ModeCntDn: next_val = q_q - WIDTH'(1);
      ModeClear: begin
        next_val = RESET_VAL;
        err_next = 1'b0;
      end
      default:   next_val = q_q;
    endcase
  end

  always_comb begin
    q_d       = q_q;
    err_d     = err_q;
    changed_d = changed_q;
    if (en) begin
      q_d       = next_val;
      err_d     = err_next;
      changed_d = (next_val != q_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign err     = err_q;
  assign changed = changed_q;
  assign tc      = en & (((mode == ModeCntUp) & (q_q == {WIDTH{1'b1}})) |
                         ((mode == ModeCntDn) & (q_q == '0)));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: 4-bit main instance plus 1-bit and 32-bit
// instances reset to all-ones for the parameter sweep.
module tb_jk_reg_bank;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [2:0]  mode;
  logic [3:0]  j4, k4;
  logic [3:0]  q4, qb4;
  logic        tc4, err4, chg4;
  logic        j1, k1, q1, qb1, tc1, err1, chg1;
  logic [31:0] j32, k32, q32, qb32;
  logic        tc32, err32, chg32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(4), .RESET_VAL(4'h0)) u_w4 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j4), .k(k4),
    .q(q4), .q_bar(qb4), .tc(tc4), .err(err4), .changed(chg4)
  );

  jk_reg_bank #(.WIDTH(1), .RESET_VAL(1'b1)) u_w1 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j1), .k(k1),
    .q(q1), .q_bar(qb1), .tc(tc1), .err(err1), .changed(chg1)
  );

  jk_reg_bank #(.WIDTH(32), .RESET_VAL(32'hffff_ffff)) u_w32 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j32), .k(k32),
    .q(q32), .q_bar(qb32), .tc(tc32), .err(err32), .changed(chg32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change only here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 3'd0;
    j4 = '0; k4 = '0; j1 = 1'b0; k1 = 1'b0; j32 = '0; k32 = '0;
    #1;
    step(); step();
    chk("rst_q", 32'(q4), 32'h0);
    chk("rst_qbar", 32'(qb4), 32'hf);
    chk("rst_err", 32'(err4), 32'h0);
    chk("rst_chg", 32'(chg4), 32'h0);
    chk("rst_tc", 32'(tc4), 32'h0);

    // JK walk
    reset = 1'b0; mode = 3'd1; j4 = 4'b1010; k4 = 4'b0101;
    step();
    chk("jk_set_q", 32'(q4), 32'ha);
    chk("jk_set_qbar", 32'(qb4), 32'h5);
    chk("jk_set_chg", 32'(chg4), 32'h1);
    j4 = 4'hf; k4 = 4'hf;
    step();
    chk("jk_tog_q", 32'(q4), 32'h5);
    j4 = 4'h0; k4 = 4'h0;
    step();
    chk("jk_hold_q", 32'(q4), 32'h5);
    chk("jk_hold_chg", 32'(chg4), 32'h0);

    // Up-count wrap
    mode = 3'd2; j4 = 4'he;
    step();
    chk("d_load", 32'(q4), 32'he);
    mode = 3'd5;
    #1 chk("up_tc_e", 32'(tc4), 32'h0);
    step();
    chk("up_q_f", 32'(q4), 32'hf);
    chk("up_tc_f", 32'(tc4), 32'h1);
    step();
    chk("up_q_0", 32'(q4), 32'h0);
    chk("up_tc_0", 32'(tc4), 32'h0);
    step();
    chk("up_q_1", 32'(q4), 32'h1);
    chk("up_chg", 32'(chg4), 32'h1);

    // Down-count with enable gap
    mode = 3'd6;
    #1 chk("dn_tc_1", 32'(tc4), 32'h0);
    step();
    chk("dn_q_0", 32'(q4), 32'h0);
    chk("dn_tc_0", 32'(tc4), 32'h1);
    en = 1'b0;
    #1 chk("dn_tc_en0", 32'(tc4), 32'h0);
    step();
    chk("dn_hold_q", 32'(q4), 32'h0);
    chk("dn_hold_chg", 32'(chg4), 32'h1);
    en = 1'b1;
    #1 chk("dn_tc_en1", 32'(tc4), 32'h1);
    step();
    chk("dn_wrap_q", 32'(q4), 32'hf);
    chk("dn_wrap_chg", 32'(chg4), 32'h1);

    // SR with illegal bits
    mode = 3'd7;
    step();
    chk("clr_q", 32'(q4), 32'h0);
    mode = 3'd4; j4 = 4'b0011; k4 = 4'b0110;
    step();
    chk("sr_q", 32'(q4), 32'h1);
    chk("sr_err", 32'(err4), 32'h1);
    mode = 3'd0;
    step();
    chk("sr_hold_err", 32'(err4), 32'h1);
    chk("sr_hold_chg", 32'(chg4), 32'h0);
    mode = 3'd7;
    step();
    chk("sr_clr_q", 32'(q4), 32'h0);
    chk("sr_clr_err", 32'(err4), 32'h0);

    // T mode, then reset in the middle of counting
    mode = 3'd2; j4 = 4'hf;
    step();
    mode = 3'd3; j4 = 4'b0101;
    step();
    chk("t_q", 32'(q4), 32'ha);
    mode = 3'd4; j4 = 4'hf; k4 = 4'hf;
    step();
    chk("sr_all_q", 32'(q4), 32'ha);
    chk("sr_all_err", 32'(err4), 32'h1);
    mode = 3'd5;
    step();
    chk("cnt_b", 32'(q4), 32'hb);
    reset = 1'b1;
    step();
    chk("midrst_q", 32'(q4), 32'h0);
    chk("midrst_chg", 32'(chg4), 32'h0);
    chk("midrst_err", 32'(err4), 32'h0);

    // X on ignored j/k inputs
    reset = 1'b0; j4 = 4'bxxxx; k4 = 4'bxxxx;
    step();
    chk("x_cnt_q", 32'(q4), 32'h1);
    mode = 3'd0;
    step();
    chk("x_hold_q", 32'(q4), 32'h1);
    j4 = '0; k4 = '0;

    // Parameter sweep at WIDTH=1 and WIDTH=32
    reset = 1'b1;
    step();
    chk("w1_rst_q", 32'(q1), 32'h1);
    chk("w32_rst_q", q32, 32'hffff_ffff);
    chk("w32_rst_qbar", qb32, 32'h0);
    reset = 1'b0; mode = 3'd5;
    #1;
    chk("w1_tc", 32'(tc1), 32'h1);
    chk("w32_tc", 32'(tc32), 32'h1);
    step();
    chk("w1_wrap_q", 32'(q1), 32'h0);
    chk("w32_wrap_q", q32, 32'h0);
    chk("w32_wrap_tc", 32'(tc32), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

A parametrised, multi-bit successor to the team's single-bit JK flip-flop: WIDTH independent JK cells behind one clock. A runtime mode selects JK, D, T, SR, synchronous up/down counting or clear. The bank adds clock enable, terminal-count detection, a sticky illegal-SR error flag and a registered change pulse. It is the general-purpose state register for control paths that previously instantiated arrays of single-bit flip-flops.

## Interface

- WIDTH, default 8: number of cells; legal range 1-32.
- RESET_VAL, default 0 (WIDTH bits): value loaded into q on reset and on CLEAR.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; clock clk.
- en  input  1  clock enable; 0 means every register holds, including err and changed.
- mode  input  3  operation select; encoding is given under Operation.
- j  input  WIDTH  J input per cell; D data in D mode, toggle mask in T mode, set in SR mode.
- k  input  WIDTH  K input per cell; clear in SR mode; ignored in D, T, COUNT and CLEAR modes.
- q  output  WIDTH  cell state.
- q_bar  output  WIDTH  always equal to ~q; never independently registered.
- tc  output  1  combinational terminal count.
- err  output  1  sticky flag for an illegal SR request.
- changed  output  1  registered pulse, high when q changed on the previous enabled edge.

## Operation

- Priority at each rising edge: reset, then en==0 (hold everything), then mode.
- Per-bit behaviour by mode:
  - 0 HOLD: q unchanged.
  - 1 JK: {j,k}=00 hold, 01 clear, 10 set, 11 toggle.
  - 2 D: q <= j.
  - 3 T: q <= q ^ j.
  - 4 SR: j=1,k=0 sets; j=0,k=1 clears; 00 holds. Where j&k is nonzero, those bits hold and err is set; the other bits still update.
  - 5 COUNT_UP: q <= q + 1, modulo 2^WIDTH.
  - 6 COUNT_DN: q <= q - 1, modulo 2^WIDTH.
  - 7 CLEAR: q <= RESET_VAL and err <= 0.
- Counter arithmetic is unsigned and exactly WIDTH bits; the carry out is discarded. All-ones wraps to 0 and 0 wraps to all-ones.
- tc = en & ((mode==5 & q==all-ones) | (mode==6 & q==0)). It is combinational from current q/mode/en and is never high in other modes.
- err is set by any SR-mode edge with en=1 and (j & k) != 0. It stays set until reset, or an enabled CLEAR edge. If the set condition and CLEAR could coincide they cannot, since the mode differs.
- changed <= (q_next != q) on every enabled edge. It holds its value when en=0 and is 0 after reset.
- Reset values: q=RESET_VAL, q_bar=~RESET_VAL, err=0, changed=0. tc follows from its equation.
- Reset mid-count wins over any mode on the same edge. The count restarts from RESET_VAL.
- X on j/k in modes that ignore them must not affect q.

## Timing

- q, err and changed: one-cycle latency from inputs sampled at the rising edge.
- tc: zero latency and combinational. A downstream register that samples tc at edge N sees the wrap take effect on q at that same edge N.
- Mode may change every cycle with no dead cycle. Each edge uses the mode present at that edge.
- No multicycle paths. The WIDTH-bit incrementer/decrementer must close timing at the team's standard clock for WIDTH<=32.

## Test plan

- Reset then JK walk, WIDTH=4, RESET_VAL=0: assert reset 2 cycles, then mode=1 with j=1010,k=0101 → q=1010, q_bar=0101, changed=1 the next cycle. Then j=k=1111 → q=0101. Then j=k=0 → q holds and changed=0.
- Up-count wrap, WIDTH=4: D-load 1110 then mode=5 for 3 edges → q=1111, 0000, 0001. tc=1 only while q=1111 and mode=5.
- Down-count wrap with enable gaps: from q=0001, mode=6, en toggling 1,0,1 → q=0000, 0000, 1111. tc=1 at q=0000 only in the cycle where en=1.
- SR illegal: q=0000, mode=4, j=0011,k=0110 → q=0001 and err=1. A following HOLD keeps err=1. CLEAR gives q=RESET_VAL and err=0.
- T mode and mid-operation reset: q=1111, mode=3, j=0101 → q=1010. Assert reset during mode=5 counting → q=RESET_VAL, changed=0, err=0 on the next edge.
- Parameter sweep: WIDTH=1 and WIDTH=32 with RESET_VAL=all-ones → reset gives q=all-ones. COUNT_UP then gives q=0 and tc=1 beforehand.
